// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: FSM state encoding (same as the TX side) and frame width.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; reset value is all ones (idle line).
// Latency: 2 clocks. No backpressure; samples every clock.
module uart_rx_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; optional stop-bit check via UART_RX_FRAME_ERR_EN.
// Latency: DV pulses 2+H+9*CLKS_PER_BIT clocks after the synchronized start edge, H=(CLKS_PER_BIT-1)/2.
// Backpressure: none; the consumer must take o_Rx_Byte on the single-cycle o_Rx_DV pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_Rx_Frame_Err
`endif
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     clk_count, clk_count_nxt;
  logic [2:0]           bit_index, bit_index_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_nxt;
  logic [7:0]           rx_byte_nxt;
  logic                 rx_dv_nxt;
  logic                 frame_err_nxt;
  logic                 stop_ok;

  uart_rx_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (i_Clk),
    .rst (i_Rst),
    .d   (i_Rx_Serial),
    .q   (rx_s)
  );

  // Without the frame-error option the stop bit is never inspected.
`ifdef UART_RX_FRAME_ERR_EN
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= s_IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      o_Rx_Byte <= 8'h00;
      o_Rx_DV   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_count <= clk_count_nxt;
      bit_index <= bit_index_nxt;
      shift_reg <= shift_reg_nxt;
      o_Rx_Byte <= rx_byte_nxt;
      o_Rx_DV   <= rx_dv_nxt;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) o_Rx_Frame_Err <= 1'b0;
    else       o_Rx_Frame_Err <= frame_err_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      s_IDLE:         if (!rx_s) state_nxt = s_RX_START_BIT;
      s_RX_START_BIT: if (clk_count == CNT_HALF) state_nxt = rx_s ? s_IDLE : s_RX_DATA_BITS;
      s_RX_DATA_BITS: if (clk_count == CNT_LAST && bit_index == BIT_LAST) state_nxt = s_RX_STOP_BIT;
      s_RX_STOP_BIT:  if (clk_count == CNT_LAST) state_nxt = s_CLEANUP;
      s_CLEANUP:      state_nxt = s_IDLE;
      default:        state_nxt = s_IDLE;
    endcase
  end

  always_comb begin
    clk_count_nxt = clk_count;
    bit_index_nxt = bit_index;
    shift_reg_nxt = shift_reg;
    rx_byte_nxt   = o_Rx_Byte;
    rx_dv_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      s_IDLE: begin
        clk_count_nxt = '0;
        bit_index_nxt = '0;
      end
      s_RX_START_BIT: begin
        if (clk_count == CNT_HALF) clk_count_nxt = '0;
        else                       clk_count_nxt = clk_count + CNT_W'(1);
      end
      s_RX_DATA_BITS: begin
        if (clk_count == CNT_LAST) begin
          clk_count_nxt            = '0;
          shift_reg_nxt[bit_index] = rx_s;
          bit_index_nxt            = bit_index + 3'd1;
        end else begin
          clk_count_nxt = clk_count + CNT_W'(1);
        end
      end
      s_RX_STOP_BIT: begin
        if (clk_count == CNT_LAST) begin
          clk_count_nxt = '0;
          if (stop_ok) begin
            rx_byte_nxt = shift_reg;
            rx_dv_nxt   = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          clk_count_nxt = clk_count + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule
